// File: rtl/save_ram_dumper_pkg.sv
// save_ram_dumper_pkg
//   Shared types and constants for the save-RAM dumper.
//   - state encoding localparams and the state_t enum built from them
//   - CSUM_INIT: starting value of the running byte sum
package save_ram_dumper_pkg;

    localparam logic [2:0] ENC_IDLE = 3'd0;
    localparam logic [2:0] ENC_REQ  = 3'd1;
    localparam logic [2:0] ENC_WAIT = 3'd2;
    localparam logic [2:0] ENC_SEND = 3'd3;
    localparam logic [2:0] ENC_CSUM = 3'd4;
    localparam logic [2:0] ENC_FIN  = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE = ENC_IDLE,
        ST_REQ  = ENC_REQ,
        ST_WAIT = ENC_WAIT,
        ST_SEND = ENC_SEND,
        ST_CSUM = ENC_CSUM,
        ST_FIN  = ENC_FIN
    } state_t;

    localparam logic [7:0] CSUM_INIT = 8'h00;

endpackage

// File: rtl/save_ram_dumper.sv
// save_ram_dumper
//   Streams a contiguous SDRAM region out as bytes, followed by a one-byte
//   checksum that makes the 8-bit sum of the whole stream zero. Reads are
//   issued only on the shared memory slot so the NES core keeps its port.
// Ports:
//   i_clk, i_reset     clock, synchronous active-high reset
//   i_slot             one-clk pulse marking the shared SDRAM slot
//   i_start, i_abort   begin a dump / abandon it (abort wins)
//   i_length           data byte count, sampled on start
//   o_mem_addr/_read   read address and single-clk read strobe
//   i_mem_din          read data, valid RD_LAT slots after the strobe
//   o_out_data/_valid  byte stream, accepted when valid && i_out_ready
//   o_busy, o_done     dump in progress / normal completion pulse
module save_ram_dumper
    import save_ram_dumper_pkg::*;
#(
    parameter int                ADDR_W    = 22,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 22'h3C0000,
    parameter int                LEN_W     = 16,
    parameter int                RD_LAT    = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_slot,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [LEN_W-1:0]  i_length,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_read,
    input  logic [7:0]        i_mem_din,
    output logic [7:0]        o_out_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic              o_busy,
    output logic              o_done
);

    localparam int LAT_W = $clog2(RD_LAT + 1);

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [LEN_W-1:0]    r_cnt;
    logic [7:0]          r_sum;
    logic [LAT_W-1:0]    r_lat;
    logic [7:0]          r_out_data;
    logic                r_out_valid;
    logic                w_xfer;
    logic                w_last;

    assign w_xfer = r_out_valid && i_out_ready;
    assign w_last = (r_cnt == LEN_W'(1));

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    // Next-state logic; abort overrides everything, including a start in IDLE
    always_comb begin
        w_next = r_state;
        if (i_abort) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (i_start) w_next = (i_length == '0) ? ST_CSUM : ST_REQ;
                ST_REQ:  if (i_slot) w_next = ST_WAIT;
                ST_WAIT: if (i_slot && r_lat == LAT_W'(1)) w_next = ST_SEND;
                ST_SEND: if (w_xfer) w_next = w_last ? ST_CSUM : ST_REQ;
                ST_CSUM: if (w_xfer) w_next = ST_FIN;
                ST_FIN:  w_next = ST_IDLE;
                default: w_next = ST_IDLE;
            endcase
        end
    end

    // State-decoded outputs; busy already drops in FIN alongside the done pulse
    always_comb begin
        o_busy     = (r_state != ST_IDLE) && (r_state != ST_FIN);
        o_done     = (r_state == ST_FIN);
        o_mem_read = (r_state == ST_REQ) && i_slot && !i_abort;
    end

    // Datapath: address, remaining count, running sum, latency and output byte
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_addr      <= BASE_ADDR;
            r_cnt       <= '0;
            r_sum       <= CSUM_INIT;
            r_lat       <= '0;
            r_out_data  <= 8'h00;
            r_out_valid <= 1'b0;
        end else if (i_abort) begin
            // the byte on offer this clk counts as not transferred
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_cnt  <= i_length;
                        r_addr <= BASE_ADDR;
                        r_sum  <= CSUM_INIT;
                        if (i_length == '0) begin
                            r_out_data  <= 8'h00 - CSUM_INIT;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    if (i_slot) r_lat <= LAT_W'(RD_LAT);
                end
                ST_WAIT: begin
                    if (i_slot) begin
                        r_lat <= r_lat - LAT_W'(1);
                        if (r_lat == LAT_W'(1)) begin
                            r_out_data  <= i_mem_din;
                            r_out_valid <= 1'b1;
                            r_sum       <= r_sum + i_mem_din;
                        end
                    end
                end
                ST_SEND: begin
                    if (w_xfer) begin
                        r_addr <= r_addr + ADDR_W'(1);
                        r_cnt  <= r_cnt - LEN_W'(1);
                        if (w_last) begin
                            // checksum follows the last data byte directly
                            r_out_data  <= 8'h00 - r_sum;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_out_valid <= 1'b0;
                        end
                    end
                end
                ST_CSUM: begin
                    if (w_xfer) r_out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign o_mem_addr  = r_addr;
    assign o_out_data  = r_out_data;
    assign o_out_valid = r_out_valid;

endmodule

// File: doc/save_ram_dumper.md
Name: save_ram_dumper

Overview:
Reads a contiguous region of SDRAM and streams it out as bytes to the OSD co-CPU, one byte per valid/ready handshake. It is the upload counterpart of the game loader, which turns an incoming byte stream into memory writes. Its main use is exporting battery-backed PRG-RAM, such as game saves, while the NES core is halted. Memory reads are issued only in the NES memory slot, so the block shares the SDRAM port with the core.

Parameters:
ADDR_W, 22, memory byte-address width.
BASE_ADDR, 22'h3C0000, first address dumped.
LEN_W, 16, width of the length input.
RD_LAT, 1, number of slot pulses between issuing a read and mem_din being valid.

Ports:
clk  in  1  system clock (21 MHz domain).
reset  in  1  synchronous, active-high.
slot  in  1  one-clk pulse marking the shared SDRAM slot (nes_ce==3).
start  in  1  one-clk pulse; begins a dump.
abort  in  1  level; ends the dump at the next clk.
length  in  LEN_W  number of data bytes; sampled on start.
mem_addr  out  ADDR_W  read address.
mem_read  out  1  read strobe; high for exactly the clk of a slot pulse.
mem_din  in  8  read data; valid on the RD_LAT-th slot after mem_read.
out_data  out  8  streamed byte.
out_valid  out  1  out_data valid.
out_ready  in  1  consumer accepts the byte when valid&&ready.
busy  out  1  dump in progress.
done  out  1  one-clk pulse at normal completion only.

Behaviour:
- Reset values: mem_addr=BASE_ADDR, mem_read=0, out_data=0, out_valid=0, busy=0, done=0. The FSM, counter and checksum all clear.
- States: IDLE, REQ, WAIT, SEND, CSUM, FIN.
- IDLE:
  - On start with length!=0: latch length into cnt, set addr=BASE_ADDR, sum=0, busy=1, go to REQ.
  - On start with length==0: go directly to CSUM, which emits checksum 0x00.
  - start is ignored while busy=1.
- REQ: wait for a slot pulse. In that clk, drive mem_read=1 with mem_addr=addr, load lat=RD_LAT, go to WAIT.
- WAIT:
  - Each slot pulse decrements lat.
  - On the slot where lat reaches 0, capture mem_din into out_data, set out_valid=1, set sum=sum+mem_din (mod 256), go to SEND.
- SEND:
  - When out_valid&&out_ready: out_valid=0, addr=addr+1 (wraps modulo 2^ADDR_W), cnt=cnt-1.
  - If cnt was 1, go to CSUM. Otherwise go to REQ.
  - out_data is held stable while out_valid=1 and out_ready=0.
- CSUM:
  - out_data = (-sum) mod 256, out_valid=1. This makes the 8-bit sum of all emitted bytes equal 0.
  - On accept, go to FIN.
- FIN: done=1 for one clk, busy=0, return to IDLE.
- Stream is exactly length+1 bytes: data bytes then the checksum.
- Throughput limit: at most one data byte per (RD_LAT+1) slot periods. A new read is never issued before the previous byte has been accepted. No buffering beyond the out_data register.
- mem_read never asserts outside a slot clk and never for more than one clk.
- abort, from any non-IDLE state: at the next clk, out_valid=0, mem_read=0, busy=0, no done pulse, return to IDLE. abort has priority over a same-cycle handshake, and that byte is considered not transferred.
- start and abort in the same clk while in IDLE: abort wins, the block stays IDLE.
- reset mid-dump: identical to the reset values above. An outstanding read is dropped; its data is never captured.
- length=2^LEN_W-1 is legal. cnt is LEN_W bits wide and must not overflow.

Decomposition:
- Shared package: state enum and localparams for the state encoding, plus a CSUM_INIT constant (8'h00).
- No sub-module is warranted. The handshake output register stays inline.
- The top level muxes mem_addr/mem_read onto the SDRAM addr/oeA path while busy, the same way loader writes are muxed while downloading.

Test Plan:
- Preload BASE_ADDR..+3 = 11,22,33,44; length=4; slot every 4th clk; out_ready=1 → bytes 11,22,33,44,56 (the checksum is −0xAA mod 256 = 0x56), one done pulse, busy falls after the last byte.
- Same data with out_ready toggling 1/0 every clk → identical byte sequence, out_data stable while stalled, mem_read only on slot clks.
- length=0 → single byte 0x00, then done.
- Abort asserted during the 3rd byte's SEND → stream stops after 2 bytes, no done pulse, busy=0 next clk; a following start with length=1 succeeds normally.
- RD_LAT=2 → mem_din is sampled on the 2nd slot after mem_read; a mem_din value changed on the 1st slot is ignored.
- Synchronous reset while in WAIT → all outputs return to their reset values next clk, and no byte is emitted afterwards.
